mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div_pkg.sv | 35 +++
 rtl/mult_div.sv | 128 ++++++++++++
 tb/tb_mult_div.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared types, constants and helpers for the iterative multiply/divide unit.
// The sign-handling helpers keep the datapath working on magnitudes only.
package mult_div_pkg;

  localparam int ITER_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return (~v) + 64'd1;
  endfunction

  // Magnitude of v, treating it as two's complement only for signed ops.
  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mult_div.sv
// Iterative 32x32 multiply / 32/32 divide: shift-add multiply and restoring
// divide on magnitudes sharing one 64-bit working register, sign fix at the end.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

  state_e      state_reg, state_next;
  op_e         op_reg;
  logic [4:0]  cnt_reg;
  logic [63:0] work_reg;
  logic [31:0] opnd_reg;
  logic        neg_reg, rem_neg_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        busy_reg, done_reg, div_zero_reg;

  logic        start_div, start_zero, start_signed;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_top, div_diff;
  logic        div_ge;
  logic [63:0] div_step;

  assign start_div    = op[1];
  assign start_zero   = start_div && (b == 32'd0);
  assign start_signed = !op[0];

  // Multiply: add the multiplicand into the upper half when the LSB is set, then shift right.
  assign mul_sum  = {1'b0, work_reg[63:32]} + {1'b0, opnd_reg};
  assign mul_step = work_reg[0] ? {mul_sum, work_reg[31:1]} : {1'b0, work_reg[63:1]};

  // Divide: the partial remainder needs 33 bits after the left shift.
  assign div_top  = work_reg[63:31];
  assign div_ge   = div_top >= {1'b0, opnd_reg};
  assign div_diff = div_top - {1'b0, opnd_reg};
  assign div_step = div_ge ? {div_diff[31:0], work_reg[30:0], 1'b1}
                           : {div_top[31:0], work_reg[30:0], 1'b0};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (start_zero)     state_next = DONE;
          else if (start_div) state_next = DIV;
          else                state_next = MUL;
        end
      end
      MUL, DIV: if (cnt_reg == LAST_ITER) state_next = FIX;
      FIX:      state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      op_reg       <= OP_MULT;
      cnt_reg      <= 5'd0;
      work_reg     <= 64'd0;
      opnd_reg     <= 32'd0;
      neg_reg      <= 1'b0;
      rem_neg_reg  <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg       <= op_e'(op);
            cnt_reg      <= 5'd0;
            work_reg     <= {32'd0, abs_val(a, start_signed)};
            opnd_reg     <= abs_val(b, start_signed);
            neg_reg      <= start_signed && (a[31] ^ b[31]);
            rem_neg_reg  <= start_signed && a[31];
            div_zero_reg <= start_zero;
          end
        end
        MUL: begin
          work_reg <= mul_step;
          cnt_reg  <= cnt_reg + 5'd1;
        end
        DIV: begin
          work_reg <= div_step;
          cnt_reg  <= cnt_reg + 5'd1;
        end
        FIX: begin
          if (op_reg == OP_DIV || op_reg == OP_DIVU) begin
            lo_reg <= neg_reg     ? neg32(work_reg[31:0])  : work_reg[31:0];
            hi_reg <= rem_neg_reg ? neg32(work_reg[63:32]) : work_reg[63:32];
          end else begin
            {hi_reg, lo_reg} <= neg_reg ? neg64(work_reg) : work_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference result {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = 64'(sx * sy); return p; end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; return p; end
      2'b10: begin
        q = sx / sy; r = sx % sy;
        qv = 64'(q); rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      default: return {x % y, x / y};
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bit dz;
    int k;
    dz = o[1] && (y == 32'd0);
    if (!dz) {exp_hi, exp_lo} = ref_model(o, x, y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    check("busy_after_start", 64'(busy), 64'd1);
    k = 0;
    while (!done && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    check($sformatf("latency op=%0d a=%h b=%h", o, x, y), 64'(k), dz ? 64'd0 : 64'd33);
    check($sformatf("hi op=%0d a=%h b=%h", o, x, y), 64'(hi), 64'(exp_hi));
    check($sformatf("lo op=%0d a=%h b=%h", o, x, y), 64'(lo), 64'(exp_lo));
    check("div_zero", 64'(div_zero), 64'(dz));
    @(posedge clock); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d latency=%0d", o, x, y, hi, lo, div_zero, k);
  endtask

  initial begin
    int pulses;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);

    run_op(2'b00, 32'd7, 32'hFFFFFFFD);
    check("mult_7_m3_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_7_m3_lo", 64'(lo), 64'hFFFFFFEB);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
    check("multu_max_lo", 64'(lo), 64'h00000001);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2);
    check("div_m7_2_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_m7_2_hi", 64'(hi), 64'hFFFFFFFF);
    run_op(2'b11, 32'd100, 32'd7);
    check("divu_100_7", {32'(hi), 32'(lo)}, {32'd2, 32'd14});
    run_op(2'b10, 32'd5, 32'd0);
    run_op(2'b00, 32'h12345678, 32'h00000010);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    check("div_overflow", {32'(hi), 32'(lo)}, {32'd0, 32'h80000000});
    run_op(2'b11, 32'd9, 32'd0);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE);

    // Reset in the middle of a multiply: no completion, results cleared.
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'h12345678; b = 32'h9ABCDEF0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    $display("reset mid-operation: busy=%0d hi=%h lo=%h done_pulses=%0d", busy, hi, lo, pulses);

    // A second start while busy must be ignored.
    {exp_hi, exp_lo} = ref_model(2'b11, 32'd1000, 32'd3);
    @(negedge clock);
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 4) begin
        @(negedge clock);
        start = 1'b1; op = 2'b01; a = 32'hDEADBEEF; b = 32'h0BADF00D;
      end
      @(posedge clock); #1;
      start = 1'b0;
      if (done) pulses++;
    end
    check("restart_one_done", 64'(pulses), 64'd1);
    check("restart_result", {32'(hi), 32'(lo)}, {32'(exp_hi), 32'(exp_lo)});
    $display("start while busy: done_pulses=%0d hi=%h lo=%h", pulses, hi, lo);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50));
      rb = $urandom;
      if ($urandom_range(0, 7) == 0)      rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      else if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      run_op(ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
